// File: rtl/sme_drain_pkg.sv
// sme_drain_pkg: shared types for the SME match drainer.
// Holds the FSM state enum, context widths and the context merge helper.
package sme_drain_pkg;

   localparam int PREAMBLE_W = 64;
   localparam int LEN_W      = 3;

   typedef enum logic [2:0] {
      IDLE, LOAD, REPLAY, STREAM, SETTLE, SAVE, DRAIN, GAP
   } drain_state_t;

   // Newest bytes first; the old context slides up behind them
   // and whatever falls past byte 7 is dropped.
   function automatic logic [PREAMBLE_W-1:0] ctx_merge(
      input logic [PREAMBLE_W-1:0] nw,
      input logic [PREAMBLE_W-1:0] od
   );
      logic [PREAMBLE_W-1:0] r;
      int n, o, s;
      n = int'(nw[LEN_W-1:0]);
      o = int'(od[LEN_W-1:0]);
      r = '0;
      for (int k = 1; k < 8; k++) begin
         if (k <= n)
            r[8*k +: 8] = nw[8*k +: 8];
         else if (k - n <= o)
            r[8*k +: 8] = od[8*(k-n) +: 8];
      end
      s = n + o;
      r[LEN_W-1:0] = (s > 7) ? 3'd7 : LEN_W'(s);
      return r;
   endfunction

endpackage

// File: rtl/sme_match_drainer_if.sv
// sme_match_drainer_if: match beat stream (valid/ready).
// master: m_valid, m_index, m_hit, m_error, m_last, m_overflow, m_slot out;
// m_ready in.  slave: the mirror image.
interface sme_match_drainer_if #(
   parameter int INDEX_W = 13,
   parameter int SLOT_W  = 4
);
   logic               m_valid;
   logic               m_ready;
   logic [INDEX_W-1:0] m_index;
   logic               m_hit;
   logic               m_error;
   logic               m_last;
   logic               m_overflow;
   logic [SLOT_W-1:0]  m_slot;

   modport master (
      output m_valid, m_index, m_hit, m_error,
      output m_last, m_overflow, m_slot,
      input  m_ready
   );

   modport slave (
      input  m_valid, m_index, m_hit, m_error,
      input  m_last, m_overflow, m_slot,
      output m_ready
   );
endinterface

// File: rtl/sme_ctx_ram.sv
// sme_ctx_ram: per-flow context table, single port, synchronous read.
// Ports: clk, we, addr, wdata in; rdata out (registered, one cycle).
module sme_ctx_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [W-1:0]             wdata,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/sme_match_drainer.sv
// sme_match_drainer: restores per-flow context into the SME, holds off
// bytes during replay, drains the SME match list as a beat stream and
// saves the merged context back to the flow table.
// Ports: clk, rst_n; cmd_* packet start; in_valid/in_last/in_ready byte
// gate; preamble_state/reload context restore; next_index, match_*,
// last_bytes_state SME side; m (match stream, master).
// Optional: SME_DRAIN_STATS_EN adds stat_hits and stat_overflows.
module sme_match_drainer
   import sme_drain_pkg::*;
#(
   parameter int FLOW_SLOTS    = 16,
   parameter int INDEX_W       = 13,
   parameter int SETTLE_CYCLES = 4,
   parameter int MAX_MATCHES   = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [$clog2(FLOW_SLOTS)-1:0] cmd_slot,
   input  logic                          cmd_new,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic                          in_valid,
   input  logic                          in_last,
   output logic                          in_ready,
   output logic [PREAMBLE_W-1:0]         preamble_state,
   output logic                          reload,
   output logic                          next_index,
   input  logic [INDEX_W-1:0]            match_index,
   input  logic                          match_valid,
   input  logic                          match_error,
   input  logic [PREAMBLE_W-1:0]         last_bytes_state,
`ifdef SME_DRAIN_STATS_EN
   output logic [31:0]                   stat_hits,
   output logic [31:0]                   stat_overflows,
`endif
   sme_match_drainer_if.master           m
);
   localparam int SLOT_W = $clog2(FLOW_SLOTS);
   localparam int HIT_W  = $clog2(MAX_MATCHES + 1);

   drain_state_t          state, state_n;
   logic [7:0]            cnt, cnt_n;
   logic [HIT_W-1:0]      hits, hits_n;
   logic [SLOT_W-1:0]     slot_q, ram_addr;
   logic                  new_q, run_q, reload_q;
   logic                  ram_we, hit_beat;
   logic [PREAMBLE_W-1:0] pre_q, ram_rdata, ram_wdata, ld_ctx;

   // run_q keeps cmd_ready low until the first edge after reset
   assign cmd_ready      = run_q && (state == IDLE);
   assign ld_ctx         = new_q ? '0 : ram_rdata;
   assign ram_addr       = (state == SAVE) ? slot_q : cmd_slot;
   assign ram_wdata      = ctx_merge(last_bytes_state, pre_q);
   assign hit_beat       = match_valid && (hits < HIT_W'(MAX_MATCHES));
   assign reload         = reload_q;
   assign preamble_state = pre_q;
   assign m.m_slot       = slot_q;

   sme_ctx_ram #(
      .DEPTH (FLOW_SLOTS),
      .W     (PREAMBLE_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         hits     <= '0;
         slot_q   <= '0;
         new_q    <= 1'b0;
         run_q    <= 1'b0;
         reload_q <= 1'b0;
         pre_q    <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         hits     <= hits_n;
         run_q    <= 1'b1;
         reload_q <= (state == LOAD);
         if (cmd_valid && cmd_ready) begin
            slot_q <= cmd_slot;
            new_q  <= cmd_new;
         end
         if (state == LOAD)
            pre_q <= ld_ctx;
      end
   end

   always_comb begin
      state_n      = state;
      cnt_n        = cnt;
      hits_n       = hits;
      in_ready     = 1'b0;
      next_index   = 1'b0;
      ram_we       = 1'b0;
      m.m_valid    = 1'b0;
      m.m_index    = '0;
      m.m_hit      = 1'b0;
      m.m_error    = 1'b0;
      m.m_last     = 1'b0;
      m.m_overflow = 1'b0;
      unique case (state)
         IDLE:
            if (cmd_valid && cmd_ready)
               state_n = LOAD;
         LOAD: begin
            cnt_n   = 8'(ld_ctx[LEN_W-1:0]);
            state_n = (ld_ctx[LEN_W-1:0] == '0) ? STREAM : REPLAY;
         end
         REPLAY:
            if (cnt == 8'd0)
               state_n = STREAM;
            else
               cnt_n = cnt - 8'd1;
         STREAM: begin
            in_ready = 1'b1;
            if (in_valid && in_last) begin
               cnt_n   = '0;
               state_n = SETTLE;
            end
         end
         SETTLE:
            if (cnt == 8'(SETTLE_CYCLES - 1))
               state_n = SAVE;
            else
               cnt_n = cnt + 8'd1;
         SAVE: begin
            ram_we  = 1'b1;
            hits_n  = '0;
            state_n = DRAIN;
         end
         DRAIN: begin
            m.m_valid = 1'b1;
            if (hit_beat) begin
               m.m_hit   = 1'b1;
               m.m_index = match_index;
               m.m_error = match_error;
               if (m.m_ready) begin
                  next_index = 1'b1;
                  hits_n     = hits + HIT_W'(1);
                  cnt_n      = '0;
                  state_n    = GAP;
               end
            end else begin
               m.m_last     = 1'b1;
               m.m_overflow = match_valid;
               if (m.m_ready)
                  state_n = IDLE;
            end
         end
         GAP:
            if (cnt == 8'd1)
               state_n = DRAIN;
            else
               cnt_n = cnt + 8'd1;
         default:
            state_n = IDLE;
      endcase
   end

`ifdef SME_DRAIN_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits      <= '0;
         stat_overflows <= '0;
      end else if (m.m_valid && m.m_ready) begin
         if (m.m_hit)
            stat_hits <= stat_hits + 32'd1;
         if (m.m_overflow)
            stat_overflows <= stat_overflows + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sme_match_drainer.sv
// tb_sme_match_drainer: directed bench with a beat scoreboard.
// A small SME stand-in serves hit lists and advances on next_index.
module tb_sme_match_drainer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  cmd_slot;
   logic        cmd_new, cmd_valid, cmd_ready;
   logic        in_valid, in_last, in_ready;
   logic [63:0] preamble_state;
   logic        reload, next_index;
   logic [12:0] match_index;
   logic        match_valid, match_error;
   logic [63:0] last_bytes_state;
`ifdef SME_DRAIN_STATS_EN
   logic [31:0] stat_hits, stat_overflows;
`endif

   always #5 clk = ~clk;

   sme_match_drainer_if #(.INDEX_W(13), .SLOT_W(4)) mif ();

   sme_match_drainer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_slot         (cmd_slot),
      .cmd_new          (cmd_new),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .in_valid         (in_valid),
      .in_last          (in_last),
      .in_ready         (in_ready),
      .preamble_state   (preamble_state),
      .reload           (reload),
      .next_index       (next_index),
      .match_index      (match_index),
      .match_valid      (match_valid),
      .match_error      (match_error),
      .last_bytes_state (last_bytes_state),
`ifdef SME_DRAIN_STATS_EN
      .stat_hits        (stat_hits),
      .stat_overflows   (stat_overflows),
`endif
      .m                (mif)
   );

   // SME stand-in: a list of hits, advanced by next_index
   logic [12:0] hits_arr [16];
   logic        err_arr  [16];
   int          hit_cnt = 0;
   int          hit_ptr = 0;
   logic        sme_clr = 1'b0;

   always @(posedge clk)
      if (sme_clr)
         hit_ptr <= 0;
      else if (next_index)
         hit_ptr <= hit_ptr + 1;

   assign match_valid = (hit_ptr < hit_cnt);
   assign match_index = hits_arr[hit_ptr[3:0]];
   assign match_error = match_valid && err_arr[hit_ptr[3:0]];

   typedef struct packed {
      logic [12:0] idx;
      logic        hit;
      logic        err;
      logic        last;
      logic        ovf;
      logic [3:0]  slot;
   } beat_t;

   beat_t exp_q[$];
   int    n_vec  = 0;
   int    n_bad  = 0;
   int    ni_cnt = 0;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, got, exp);
      end
   endtask

   task automatic push_beat(input logic [12:0] idx, input logic hit,
                            input logic err, input logic last,
                            input logic ovf, input logic [3:0] slot);
      exp_q.push_back('{idx, hit, err, last, ovf, slot});
   endtask

   // monitor: every accepted beat is checked against the queue head
   always @(negedge clk) begin
      beat_t got, e;
      if (rst_n && next_index)
         ni_cnt++;
      if (rst_n && mif.m_valid && mif.m_ready) begin
         got = {mif.m_index, mif.m_hit, mif.m_error,
                mif.m_last, mif.m_overflow, mif.m_slot};
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL beat_unexpected: got %h required none", got);
         end else begin
            e = exp_q.pop_front();
            chk("beat", 64'(got), 64'(e));
         end
      end
   end

   task automatic set_hits(input int n);
      hit_cnt = n;
      sme_clr = 1'b1;
      @(posedge clk); #1;
      sme_clr = 1'b0;
   endtask

   task automatic chk_reset_outs();
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_reload", 64'(reload), 64'd0);
      chk("rst_next_index", 64'(next_index), 64'd0);
      chk("rst_m_valid", 64'(mif.m_valid), 64'd0);
      chk("rst_preamble", preamble_state, 64'd0);
      chk("rst_flags", 64'({mif.m_hit, mif.m_last, mif.m_overflow}), 64'd0);
   endtask

   task automatic issue_cmd(input logic [3:0] slot, input logic nw);
      int k;
      cmd_slot  = slot;
      cmd_new   = nw;
      cmd_valid = 1'b1;
      k = 0;
      @(negedge clk);
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_accept", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_reload(input logic [63:0] exp_pre);
      int k;
      k = 0;
      @(negedge clk);
      while (!reload && k < 10) begin
         @(negedge clk);
         k++;
      end
      chk("reload_lat", 64'(k), 64'd1);
      chk("preamble", preamble_state, exp_pre);
   endtask

   task automatic run_pkt(input logic [3:0] slot, input logic nw,
                          input int nbytes, input logic [63:0] lbs,
                          input logic [63:0] exp_pre, input int exp_rep,
                          input int exp_ni, input bit hold);
      int    ni0, k, g;
      beat_t e;
      ni0 = ni_cnt;
      last_bytes_state = lbs;
      issue_cmd(slot, nw);
      wait_reload(exp_pre);
      @(negedge clk);
      chk("reload_pulse", 64'(reload), 64'd0);
      g = 0;
      while (!in_ready && g < 20) begin
         g++;
         @(negedge clk);
      end
      chk("replay_cycles", 64'(g), 64'(exp_rep));
      if (hold)
         mif.m_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < nbytes; i++) begin
         in_valid = 1'b1;
         in_last  = (i == nbytes - 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (hold) begin
         k = 0;
         @(negedge clk);
         while (!mif.m_valid && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("hold_valid", 64'(mif.m_valid), 64'd1);
         e = exp_q[0];
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_index", 64'(mif.m_index), 64'(e.idx));
            chk("hold_hit", 64'(mif.m_hit), 64'(e.hit));
            chk("hold_next_index", 64'(next_index), 64'd0);
         end
         @(posedge clk); #1;
         mif.m_ready = 1'b1;
      end
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(cmd_ready && exp_q.size() == 0) && k < 400);
      chk("drain_done", 64'(cmd_ready && exp_q.size() == 0), 64'd1);
      chk("next_index_cnt", 64'(ni_cnt - ni0), 64'(exp_ni));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   initial begin
      cmd_slot = '0;
      cmd_new = 1'b0;
      cmd_valid = 1'b0;
      in_valid = 1'b0;
      in_last = 1'b0;
      last_bytes_state = '0;
      mif.m_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         hits_arr[i] = '0;
         err_arr[i]  = 1'b0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_ready_rel0", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("cmd_ready_rel1", 64'(cmd_ready), 64'd1);

      // new flow, 10 bytes, two hits
      hits_arr[0] = 13'h011;
      hits_arr[1] = 13'h7A2;
      set_hits(2);
      push_beat(13'h011, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      push_beat(13'h7A2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
      run_pkt(4'd2, 1'b1, 10, 64'h1716_1514_1312_1107,
              64'h0, 0, 2, 1'b0);

      // slot 2 replays len 7, one new byte merged in front
      set_hits(0);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
      run_pkt(4'd2, 1'b0, 1, 64'h0000_0000_0000_2101,
              64'h1716_1514_1312_1107, 7, 0, 1'b0);

      // new flow on slot 5, len 3 context, held hit beat with error
      hits_arr[0] = 13'h0AB;
      err_arr[0]  = 1'b1;
      set_hits(1);
      push_beat(13'h0AB, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      run_pkt(4'd5, 1'b1, 4, 64'hEEEE_EEEE_CCBB_AA03,
              64'h0, 0, 1, 1'b1);
      err_arr[0] = 1'b0;

      // replay len 3, then two new bytes on top
      set_hits(0);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      run_pkt(4'd5, 1'b0, 2, 64'h0000_0000_0002_0102,
              64'h0000_0000_CCBB_AA03, 3, 0, 1'b0);

      // old len 5 + two new bytes; ten persistent hits overflow
      for (int i = 0; i < 10; i++)
         hits_arr[i] = 13'h100 + 13'(i);
      set_hits(10);
      for (int i = 0; i < 8; i++)
         push_beat(13'h100 + 13'(i), 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5);
      run_pkt(4'd5, 1'b0, 2, 64'h0000_0000_0032_3102,
              64'h0000_CCBB_AA02_0105, 5, 8, 1'b0);

      // reset in the middle of replay
      set_hits(0);
      issue_cmd(4'd5, 1'b0);
      wait_reload(64'hCCBB_AA02_0132_3107);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("cmd_ready_rel0", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      chk("cmd_ready_rel1", 64'(cmd_ready), 64'd1);

      // table survives reset: slot 2 holds the merged context
      hits_arr[0] = 13'h1FFF;
      set_hits(1);
      push_beat(13'h1FFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
      push_beat(13'h000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
      run_pkt(4'd2, 1'b0, 3, 64'h0,
              64'h1615_1413_1211_2107, 7, 1, 1'b0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
